// File: rtl/preg_alloc.sv
// Rename-side allocator: captures free-register-list offers into an in-order pool and serves 1-4 registers per cycle.
// Optional duplicate detection is compiled in with `define PREG_ALLOC_DUP_CHECK_EN.
package reg_pkg;
  localparam int NUM_PHYS_REGS = 64;
endpackage

module preg_alloc #(
  parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
  parameter int POOL_DEPTH    = 8,
  parameter int FRL_LAT       = 1,
  localparam int PREG_W       = $clog2(NUM_PHYS_REGS),
  localparam int CNT_W        = $clog2(POOL_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frl_valid_in,
  input  logic [3:0][PREG_W-1:0] frl_regs_in,
  output logic [3:0]             frl_ack_out,
  input  logic                   rn_req_valid_in,
  input  logic [2:0]             rn_req_count_in,
  output logic                   rn_ready_out,
  output logic [3:0][PREG_W-1:0] rn_regs_out,
  output logic [CNT_W-1:0]       pool_count_out,
  output logic                   dup_err_out
);
  localparam int PTR_W = $clog2(POOL_DEPTH);

  typedef enum logic [1:0] {FILL, ACK, WAIT} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         wait_reg, wait_next;
  logic [3:0]         ack_reg, ack_next;
  logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [PREG_W-1:0]  pool_mem [POOL_DEPTH];

  logic [CNT_W-1:0]   free_slots;
  logic [2:0]         k;
  logic [2:0]         cap_n, pop_n;
  logic               capture, grant;
  logic [3:0]         mask;

  // Space is judged on the pre-pop count so a capture never lands on unread entries.
  always_comb begin
    free_slots = CNT_W'(POOL_DEPTH) - count_reg;
    k          = (free_slots >= CNT_W'(4)) ? 3'd4 : free_slots[2:0];
    capture    = (state_reg == FILL) && frl_valid_in && (k != 3'd0);
    mask       = 4'((5'd1 << k) - 5'd1);
    grant      = rn_req_valid_in && rn_ready_out;
    cap_n      = capture ? k : 3'd0;
    pop_n      = grant ? rn_req_count_in : 3'd0;
  end

  assign rn_ready_out   = count_reg >= CNT_W'(rn_req_count_in);
  assign pool_count_out = count_reg;
  assign frl_ack_out    = ack_reg;

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    ack_next   = 4'b0000;
    case (state_reg)
      FILL: begin
        if (capture) begin
          state_next = ACK;
          ack_next   = mask;
        end
      end
      ACK: begin
        if (FRL_LAT == 1) begin
          state_next = FILL;
        end else begin
          state_next = WAIT;
          wait_next  = 2'(FRL_LAT - 1);
        end
      end
      WAIT: begin
        wait_next = wait_reg - 2'd1;
        if (wait_reg <= 2'd1) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= FILL;
      wait_reg   <= 2'd0;
      ack_reg    <= 4'b0000;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      ack_reg    <= ack_next;
      rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_n);
      wr_ptr_reg <= wr_ptr_reg + PTR_W'(cap_n);
      count_reg  <= count_reg + CNT_W'(cap_n) - CNT_W'(pop_n);
    end
  end

  // Storage is intentionally left uninitialised; only pointers and count reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (capture && (3'(i) < k)) pool_mem[wr_ptr_reg + PTR_W'(i)] <= frl_regs_in[i];
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    assign rn_regs_out[gi] = pool_mem[rd_ptr_reg + PTR_W'(gi)];
  end

`ifdef PREG_ALLOC_DUP_CHECK_EN
  logic dup_hit;
  logic dup_reg;

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < k) begin
        for (int j = 0; j < POOL_DEPTH; j++) begin
          if ((CNT_W'(j) < count_reg) && (pool_mem[rd_ptr_reg + PTR_W'(j)] == frl_regs_in[i]))
            dup_hit = 1'b1;
        end
        for (int j = 0; j < i; j++) begin
          if (frl_regs_in[j] == frl_regs_in[i]) dup_hit = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dup_reg <= 1'b0;
    else if (capture && dup_hit) dup_reg <= 1'b1;
  end

  assign dup_err_out = dup_reg;

  a_no_dup: assert property (@(posedge clk) disable iff (rst) !(capture && dup_hit));
`else
  assign dup_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_preg_alloc.sv
// Bench for preg_alloc: queue-based reference model checked every cycle, plus directed literal checks.
module tb_preg_alloc;
  localparam int DEPTH = 8;
  localparam int LAT   = 2;
  localparam int W     = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              frl_valid_in;
  logic [3:0][W-1:0] frl_regs_in;
  logic [3:0]        frl_ack_out;
  logic              rn_req_valid_in;
  logic [2:0]        rn_req_count_in;
  logic              rn_ready_out;
  logic [3:0][W-1:0] rn_regs_out;
  logic [3:0]        pool_count_out;
  logic              dup_err_out;

  int checks = 0;
  int errors = 0;

  preg_alloc #(.NUM_PHYS_REGS(64), .POOL_DEPTH(DEPTH), .FRL_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .frl_valid_in(frl_valid_in), .frl_regs_in(frl_regs_in), .frl_ack_out(frl_ack_out),
    .rn_req_valid_in(rn_req_valid_in), .rn_req_count_in(rn_req_count_in),
    .rn_ready_out(rn_ready_out), .rn_regs_out(rn_regs_out),
    .pool_count_out(pool_count_out), .dup_err_out(dup_err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of registers and a count of cycles during which offers are ignored.
  logic [W-1:0] mq[$];
  int           busy;
  logic [3:0]   m_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      busy  <= 0;
      m_ack <= 4'b0;
    end else begin
      int n, k;
      bit g, cap;
      n   = int'(rn_req_count_in);
      g   = rn_req_valid_in && (mq.size() >= n);
      k   = DEPTH - mq.size();
      if (k > 4) k = 4;
      cap = (busy == 0) && frl_valid_in && (k > 0);
      if (g) repeat (n) void'(mq.pop_front());
      if (cap) for (int i = 0; i < k; i++) mq.push_back(frl_regs_in[i]);
      m_ack <= cap ? 4'((1 << k) - 1) : 4'b0;
      if (cap) busy <= LAT;
      else if (busy > 0) busy <= busy - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("ack", frl_ack_out, m_ack);
      check("count", pool_count_out, mq.size());
      check("ready", rn_ready_out, mq.size() >= int'(rn_req_count_in));
      check("dup", dup_err_out, 0);
      for (int i = 0; i < 4; i++)
        if (i < mq.size()) check($sformatf("regs%0d", i), rn_regs_out[i], mq[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input bit fv, input int r3, input int r2, input int r1, input int r0,
                     input bit rv, input int rc);
    frl_valid_in    = fv;
    frl_regs_in[3]  = W'(r3);
    frl_regs_in[2]  = W'(r2);
    frl_regs_in[1]  = W'(r1);
    frl_regs_in[0]  = W'(r0);
    rn_req_valid_in = rv;
    rn_req_count_in = 3'(rc);
  endtask

  initial begin
    int ack_cycles;
    rst = 1'b1;
    set(0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", frl_ack_out, 0);
    check("rst_count", pool_count_out, 0);
    check("rst_ready", rn_ready_out, 0);
    check("rst_dup", dup_err_out, 0);
    rst = 1'b0;
    tick();

    // First offer of four, fully accepted
    set(1, 3, 2, 1, 0, 0, 1);
    tick();
    check("s1_ack", frl_ack_out, 4'b1111);
    check("s1_count", pool_count_out, 4);
    check("s1_reg0", rn_regs_out[0], 0);
    set(0, 3, 2, 1, 0, 0, 1);
    tick();
    check("s1_ack_drop", frl_ack_out, 0);
    tick();

    // Reach count 6, then a partial ack of two fills the pool
    set(0, 0, 0, 0, 0, 1, 2);
    tick();
    set(1, 13, 12, 11, 10, 0, 1);
    tick();
    set(0, 13, 12, 11, 10, 0, 1);
    tick();
    tick();
    check("s2_count6", pool_count_out, 6);
    set(1, 23, 22, 21, 20, 0, 1);
    tick();
    check("s2_ack", frl_ack_out, 4'b0011);
    check("s2_count", pool_count_out, 8);
    repeat (4) tick();
    check("s2_full_ack", frl_ack_out, 0);
    check("s2_full_count", pool_count_out, 8);

    // Drain to count 3
    set(0, 0, 0, 0, 0, 1, 4);
    #1;
    check("s3_reg0", rn_regs_out[0], 2);
    check("s3_reg3", rn_regs_out[3], 11);
    tick();
    set(0, 0, 0, 0, 0, 1, 1);
    tick();
    check("s3_count", pool_count_out, 3);

    // Request of 4 with 3 held stalls while a capture of 4 lands; read wraps
    set(1, 33, 32, 31, 30, 1, 4);
    #1;
    check("s4_notready", rn_ready_out, 0);
    tick();
    check("s4_count", pool_count_out, 7);
    set(0, 33, 32, 31, 30, 1, 4);
    #1;
    check("s4_ready", rn_ready_out, 1);
    check("s4_reg0", rn_regs_out[0], 13);
    check("s4_reg1", rn_regs_out[1], 20);
    check("s4_reg3", rn_regs_out[3], 30);
    tick();
    check("s4_count_after", pool_count_out, 3);

    // Simultaneous capture of 4 and grant of 2 from count 2
    set(0, 0, 0, 0, 0, 1, 1);
    tick();
    set(1, 43, 42, 41, 40, 1, 2);
    tick();
    check("s5_count", pool_count_out, 4);
    set(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("s5_reg0", rn_regs_out[0], 40);
    check("s5_reg3", rn_regs_out[3], 43);

    // Offer held valid: one capture every third cycle
    set(1, 53, 52, 51, 50, 1, 3);
    ack_cycles = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      if (frl_ack_out != 4'b0) ack_cycles++;
    end
    check("s6_ack_cycles", ack_cycles, 3);
    check("s6_count", pool_count_out, 4);

    // Mixed directed traffic
    for (int t = 0; t < 24; t++) begin
      set((t % 3) != 1, (4*t+3) % 64, (4*t+2) % 64, (4*t+1) % 64, (4*t) % 64,
          (t % 5) != 0, (t % 4) + 1);
      tick();
    end

    // Drain, capture, then reset during the ack cycle
    set(0, 0, 0, 0, 0, 1, 1);
    repeat (9) tick();
    check("s8_empty", pool_count_out, 0);
    set(1, 63, 62, 61, 60, 0, 1);
    tick();
    check("s8_ack", frl_ack_out, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    check("s8_rst_ack", frl_ack_out, 0);
    check("s8_rst_count", pool_count_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 1);
    tick();
    check("s8_post_ack", frl_ack_out, 0);
    check("s8_post_count", pool_count_out, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/preg_alloc.md
Name: preg_alloc

Overview:
- Rename-side consumer of the free register list acquire interface; it is the other end of the free-register-list offer/ack protocol.
- Captures the 4-register offer from the free register list, acknowledges it with a low-order contiguous mask, and buffers the accepted registers in a small in-order pool.
- Serves all-or-nothing requests of 1-4 destination physical registers per cycle to the rename stage.

Parameters:
- NUM_PHYS_REGS, default reg_pkg::NUM_PHYS_REGS; physical register count. PREG_W = $clog2(NUM_PHYS_REGS).
- POOL_DEPTH, default 8; local pool entries. Must be a power of two and >= 4.
- FRL_LAT, default 1; cycles to wait after an ack before the offer is sampled again (1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- frl_valid_in  in  1  free register list offer valid.
- frl_regs_in  in  4 x PREG_W  offered registers; index 0 is the oldest.
- frl_ack_out  out  4  accepted mask, driven to the free register list's acquire_ready_in. Always low-order contiguous: 0000, 0001, 0011, 0111 or 1111.
- rn_req_valid_in  in  1  rename request valid.
- rn_req_count_in  in  3  registers requested, 1..4. Values 0 and >4 are illegal.
- rn_ready_out  out  1  pool count >= rn_req_count_in (combinational).
- rn_regs_out  out  4 x PREG_W  the pool's 4 oldest entries (combinational from the read pointer). Entries at or beyond the pool count are don't-care.
- pool_count_out  out  $clog2(POOL_DEPTH+1)  current pool occupancy.
- dup_err_out  out  1  sticky duplicate error (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): rd_ptr = wr_ptr = 0, count = 0, state = FILL, frl_ack_out = 0, dup_err_out = 0. Pool storage is not cleared.
- Pool: circular buffer with PREG_W-bit entries. rd_ptr and wr_ptr are $clog2(POOL_DEPTH) bits and wrap naturally.

FSM (registered) controlling the acquire side:
- FILL
  - k = min(4, POOL_DEPTH - count), using the pre-pop count (conservative).
  - If frl_valid_in and k > 0: write frl_regs_in[0..k-1] at wr_ptr..wr_ptr+k-1. Register frl_ack_out = (1<<k)-1 and go to ACK.
  - Otherwise stay in FILL with frl_ack_out = 0.
- ACK
  - frl_ack_out holds the mask for exactly this one cycle; no capture occurs.
  - Next state: WAIT with the wait counter loaded to FRL_LAT-1. If FRL_LAT == 1, go directly to FILL.
  - frl_ack_out returns to 0 on exit.
- WAIT
  - No capture. Decrement the wait counter; go to FILL when it reaches 0.
  - Purpose: the free register list's head must advance before a fresh offer is sampled, so a stale offer is never captured twice.

Rename side:
- Grant when rn_req_valid_in && rn_ready_out. Then rd_ptr += rn_req_count_in and count -= rn_req_count_in at the edge.
- rn_regs_out[0..n-1] are valid in the same cycle as the grant (zero-latency read).
- No partial grants. With valid high and ready low, nothing pops and the requester holds its request.

Pointer and count rules:
- Simultaneous capture and grant in one cycle: count_next = count + k - n.
- The write region never overlaps unread entries, because k uses the pre-pop free space.
- Full pool (count == POOL_DEPTH): k = 0, so no capture and no ack; the FSM stays in FILL.
- Empty pool: rn_ready_out = 0 for any legal count.
- Reset mid-ACK or mid-WAIT: the ack is dropped immediately. The free register list shares rst, so both sides reinitialise together.

Optional Feature:
- Macro: PREG_ALLOC_DUP_CHECK_EN.
- Enabled:
  - On each capture, compare every accepted register against all valid pool entries and against the other accepted lanes.
  - Any match sets dup_err_out at the next edge. It stays set until rst.
  - An SVA assertion fires on the same condition.
- Disabled: no comparators; dup_err_out is tied to 0.

Test Plan:
- Reset, then frl_valid_in = 1 with regs {3,2,1,0} (lane 3..0) -> frl_ack_out = 1111 for one cycle; pool_count_out = 4; rn_regs_out[0] = 0.
- Pool count 6 (depth 8), offer valid -> frl_ack_out = 0011; count becomes 8. Next offer in FILL -> no ack while full.
- FRL_LAT = 2, offer held valid continuously -> captures occur every 3rd cycle (FILL, ACK, WAIT). Never two captures of the same stale offer.
- Count 3, request count 4 -> rn_ready_out = 0, no pop. Same cycle capture of 4 -> next cycle count 7, request granted, count 3, rn_regs_out = first 4 in FIFO order across the wrap boundary.
- Capture of 4 and grant of 2 in the same cycle, from count 2 -> count 4; wr_ptr and rd_ptr wrap correctly at POOL_DEPTH.
- With PREG_ALLOC_DUP_CHECK_EN: offer contains reg 5 twice -> dup_err_out = 1 next cycle, stays 1; async rst mid-ACK -> frl_ack_out = 0 and dup_err_out = 0 immediately.
